multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Five-state multicycle instruction controller (FETCH/DECODE/EXEC/MEM/WB) with MEM timeout.
// Optional retirement counter output retired_cnt enabled by macro MULTICYCLE_CTRL_PERF_EN.
module multicycle_controller #(
  parameter int OPCODE_W    = 6,
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Fetch handshake: an instruction transfers on a clk edge where instr_valid && instr_ready.
  // instr_ready is high only in FETCH and does not depend on instr_valid.
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  mem_ready,
  output logic                  Reg_Dst,
  output logic                  Alu_Src,
  output logic                  Mem_To_Reg,
  output logic                  Shamt_Sel,
  output logic [ALU_CTRL_W-1:0] Alu_Control,
  output logic                  Mem_Read,
  output logic                  Mem_Write,
  output logic                  Reg_Write,
  output logic                  busy,
  output logic                  illegal_op,
  output logic                  mem_abort
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0]           retired_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(6'h01);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(6'h02);
  localparam logic [OPCODE_W-1:0] OP_INC  = OPCODE_W'(6'h03);
  localparam logic [OPCODE_W-1:0] OP_DEC  = OPCODE_W'(6'h04);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(6'h05);
  localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(6'h06);
  localparam logic [OPCODE_W-1:0] OP_XOR  = OPCODE_W'(6'h07);
  localparam logic [OPCODE_W-1:0] OP_NOT  = OPCODE_W'(6'h08);
  localparam logic [OPCODE_W-1:0] OP_SLL  = OPCODE_W'(6'h09);
  localparam logic [OPCODE_W-1:0] OP_SRL  = OPCODE_W'(6'h0A);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'h0B);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(6'h0C);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'h22);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'h24);

  state_t                state_q, state_d;
  logic [OPCODE_W-1:0]   opcode_q, opcode_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                  mem_abort_q, mem_abort_d;

  logic                  dec_legal, dec_alu_op, dec_src, dec_shamt, dec_lw, dec_sw;
  logic [ALU_CTRL_W-1:0] dec_alu;
  logic                  sel_active;

  // Decode of the latched opcode; stays stable for the whole instruction.
  always_comb begin
    dec_legal  = 1'b1;
    dec_alu_op = 1'b1;
    dec_src    = 1'b0;
    dec_shamt  = 1'b0;
    dec_lw     = 1'b0;
    dec_sw     = 1'b0;
    dec_alu    = '0;
    case (opcode_q)
      OP_ADD:  dec_alu = ALU_CTRL_W'(4'd5);
      OP_ADDI: begin dec_alu = ALU_CTRL_W'(4'd5); dec_src = 1'b1; end
      OP_SUB:  dec_alu = ALU_CTRL_W'(4'd6);
      OP_SUBI: begin dec_alu = ALU_CTRL_W'(4'd6); dec_src = 1'b1; end
      OP_INC:  dec_alu = ALU_CTRL_W'(4'd7);
      OP_DEC:  dec_alu = ALU_CTRL_W'(4'd4);
      OP_AND:  dec_alu = ALU_CTRL_W'(4'd1);
      OP_OR:   dec_alu = ALU_CTRL_W'(4'd3);
      OP_XOR:  dec_alu = ALU_CTRL_W'(4'd2);
      OP_NOT:  dec_alu = ALU_CTRL_W'(4'd0);
      OP_SLL:  begin dec_alu = ALU_CTRL_W'(4'd9);  dec_shamt = 1'b1; end
      OP_SRL:  begin dec_alu = ALU_CTRL_W'(4'd10); dec_shamt = 1'b1; end
      OP_LW: begin
        dec_alu = ALU_CTRL_W'(4'd5); dec_src = 1'b1; dec_alu_op = 1'b0; dec_lw = 1'b1;
      end
      OP_SW: begin
        dec_alu = ALU_CTRL_W'(4'd5); dec_src = 1'b1; dec_alu_op = 1'b0; dec_sw = 1'b1;
      end
      default: begin
        dec_legal  = 1'b0;
        dec_alu_op = 1'b0;
      end
    endcase
  end

  // Selects are zero in FETCH and for an undefined opcode.
  assign sel_active  = (state_q != S_FETCH) && dec_legal;
  assign Reg_Dst     = sel_active & dec_alu_op;
  assign Mem_To_Reg  = sel_active & dec_alu_op;
  assign Alu_Src     = sel_active & dec_src;
  assign Shamt_Sel   = sel_active & dec_shamt;
  assign Alu_Control = sel_active ? dec_alu : '0;
  assign busy        = (state_q != S_FETCH);
  assign mem_abort   = mem_abort_q;

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    wait_cnt_d  = wait_cnt_q;
    mem_abort_d = 1'b0;
    instr_ready = 1'b0;
    Mem_Read    = 1'b0;
    Mem_Write   = 1'b0;
    Reg_Write   = 1'b0;
    illegal_op  = 1'b0;
    case (state_q)
      S_FETCH: begin
        instr_ready = 1'b1;
        wait_cnt_d  = '0;
        if (instr_valid) begin
          opcode_d = opcode;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXEC: state_d = (dec_lw || dec_sw) ? S_MEM : S_WB;
      S_MEM: begin
        Mem_Read  = dec_lw;
        Mem_Write = dec_sw;
        // A mem_ready in the last counted cycle completes rather than aborts.
        if (mem_ready) begin
          wait_cnt_d = '0;
          state_d    = dec_lw ? S_WB : S_FETCH;
        end else if (wait_cnt_q == CNT_LAST) begin
          wait_cnt_d  = '0;
          mem_abort_d = 1'b1;
          state_d     = S_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        Reg_Write = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      opcode_q    <= '0;
      wait_cnt_q  <= '0;
      mem_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_abort_q <= mem_abort_d;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] retired_cnt_q;
  logic        retire;

  // An instruction retires when WB ends or when a store completes in MEM.
  assign retire      = (state_q == S_WB) || ((state_q == S_MEM) && dec_sw && mem_ready);
  assign retired_cnt = retired_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_cnt_q <= '0;
    end else if (retire) begin
      retired_cnt_q <= retired_cnt_q + 32'd1;
    end
  end
`endif

endmodule
